// File: rtl/char_move_arbiter.sv
// Cat/mouse step arbiter: round-robin grant, one shared maze-wall lookup, registered positions.
// Optional CATMOUSE_WRAP_EN: off-grid targets wrap to the opposite edge instead of failing.
module char_move_arbiter #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int CAT_X0   = 0,
  parameter int CAT_Y0   = 0,
  parameter int MOUSE_X0 = 31,
  parameter int MOUSE_Y0 = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cat_req,
  input  logic       mouse_req,
  input  logic [1:0] cat_dir,
  input  logic [1:0] mouse_dir,
  output logic       wall_rd,
  output logic [5:0] wall_x,
  output logic [5:0] wall_y,
  input  logic       wall_hit,
  output logic       cat_ack,
  output logic       mouse_ack,
  output logic       move_ok,
  output logic [5:0] cat_x,
  output logic [5:0] cat_y,
  output logic [5:0] mouse_x,
  output logic [5:0] mouse_y,
  output logic       caught,
  output logic [1:0] dbg_state
);

  // Handshake: a requester holds req (and dir) until its one-cycle ack; dir is
  // captured at grant, and dropping req after grant does not cancel the step.

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WAIT, S_COMMIT} state_t;

`ifdef CATMOUSE_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  localparam logic [5:0] XMAX = 6'(GRID_W - 1);
  localparam logic [5:0] YMAX = 6'(GRID_H - 1);

  state_t     state, state_n;
  logic       gnt_mouse, last_mouse, blocked;
  logic [5:0] tgt_x, tgt_y;

  logic       grant, grant_mouse, edge_hit;
  logic [1:0] src_dir;
  logic [5:0] src_x, src_y, nxt_x, nxt_y;
  logic [5:0] new_cat_x, new_cat_y, new_mouse_x, new_mouse_y;

  always_comb begin
    grant       = 1'b0;
    grant_mouse = 1'b0;
    if (state == S_IDLE && !caught && (cat_req || mouse_req)) begin
      grant       = 1'b1;
      grant_mouse = mouse_req && (!cat_req || !last_mouse);
    end
    src_x   = grant_mouse ? mouse_x   : cat_x;
    src_y   = grant_mouse ? mouse_y   : cat_y;
    src_dir = grant_mouse ? mouse_dir : cat_dir;

    // Edge cells produce the wrapped coordinate; edge_hit marks the off-grid case.
    edge_hit = 1'b0;
    nxt_x    = src_x;
    nxt_y    = src_y;
    case (src_dir)
      2'd0: if (src_x == XMAX) begin edge_hit = 1'b1; nxt_x = 6'd0; end
            else nxt_x = src_x + 6'd1;
      2'd1: if (src_y == YMAX) begin edge_hit = 1'b1; nxt_y = 6'd0; end
            else nxt_y = src_y + 6'd1;
      2'd2: if (src_x == 6'd0) begin edge_hit = 1'b1; nxt_x = XMAX; end
            else nxt_x = src_x - 6'd1;
      default: if (src_y == 6'd0) begin edge_hit = 1'b1; nxt_y = YMAX; end
               else nxt_y = src_y - 6'd1;
    endcase
  end

  always_comb begin
    state_n   = state;
    wall_rd   = 1'b0;
    cat_ack   = 1'b0;
    mouse_ack = 1'b0;
    move_ok   = 1'b0;
    case (state)
      S_IDLE:   if (grant) state_n = (edge_hit && !WRAP) ? S_COMMIT : S_LOOKUP;
      S_LOOKUP: begin
        wall_rd = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT:   state_n = S_COMMIT;
      default: begin
        cat_ack   = !gnt_mouse;
        mouse_ack = gnt_mouse;
        move_ok   = !blocked;
        state_n   = S_IDLE;
      end
    endcase
  end

  always_comb begin
    new_cat_x   = cat_x;
    new_cat_y   = cat_y;
    new_mouse_x = mouse_x;
    new_mouse_y = mouse_y;
    if (state == S_COMMIT && !blocked) begin
      if (gnt_mouse) begin
        new_mouse_x = tgt_x;
        new_mouse_y = tgt_y;
      end else begin
        new_cat_x = tgt_x;
        new_cat_y = tgt_y;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      gnt_mouse  <= 1'b0;
      last_mouse <= 1'b1;
      blocked    <= 1'b0;
      tgt_x      <= 6'd0;
      tgt_y      <= 6'd0;
      cat_x      <= 6'(CAT_X0);
      cat_y      <= 6'(CAT_Y0);
      mouse_x    <= 6'(MOUSE_X0);
      mouse_y    <= 6'(MOUSE_Y0);
      caught     <= 1'b0;
    end else begin
      state <= state_n;
      if (grant) begin
        gnt_mouse  <= grant_mouse;
        last_mouse <= grant_mouse;
        tgt_x      <= nxt_x;
        tgt_y      <= nxt_y;
        blocked    <= edge_hit && !WRAP;
      end
      if (state == S_WAIT) blocked <= wall_hit;
      cat_x   <= new_cat_x;
      cat_y   <= new_cat_y;
      mouse_x <= new_mouse_x;
      mouse_y <= new_mouse_y;
      if (state == S_COMMIT && new_cat_x == new_mouse_x && new_cat_y == new_mouse_y)
        caught <= 1'b1;
    end
  end

  assign wall_x    = tgt_x;
  assign wall_y    = tgt_y;
  assign dbg_state = state;

endmodule

// File: tb/tb_char_move_arbiter.sv
// Bench for char_move_arbiter: directed scenarios plus randomized steps against a grid-level model.
// Honours CATMOUSE_WRAP_EN the same way as the design.
module tb_char_move_arbiter;

  localparam int GRID_W = 32;
  localparam int GRID_H = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cat_req = 1'b0, mouse_req = 1'b0;
  logic [1:0] cat_dir = 2'd0, mouse_dir = 2'd0;
  logic       wall_hit = 1'b0;
  logic       wall_rd, cat_ack, mouse_ack, move_ok, caught;
  logic [5:0] wall_x, wall_y, cat_x, cat_y, mouse_x, mouse_y;
  logic [1:0] dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: index 0 = cat, 1 = mouse
  int px[2], py[2];
  bit m_last_mouse;
  bit m_caught;

  char_move_arbiter dut (
    .clk(clk), .rst(rst),
    .cat_req(cat_req), .mouse_req(mouse_req),
    .cat_dir(cat_dir), .mouse_dir(mouse_dir),
    .wall_rd(wall_rd), .wall_x(wall_x), .wall_y(wall_y), .wall_hit(wall_hit),
    .cat_ack(cat_ack), .mouse_ack(mouse_ack), .move_ok(move_ok),
    .cat_x(cat_x), .cat_y(cat_y), .mouse_x(mouse_x), .mouse_y(mouse_y),
    .caught(caught), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    px[0] = 0;  py[0] = 0;
    px[1] = 31; py[1] = 23;
    m_last_mouse = 1'b1;
    m_caught = 1'b0;
  endtask

  task automatic check_positions(input string name);
    tests_run++;
    if (cat_x !== 6'(px[0]) || cat_y !== 6'(py[0]) || mouse_x !== 6'(px[1]) ||
        mouse_y !== 6'(py[1]) || caught !== m_caught) begin
      tests_failed++;
      $display("FAIL %s: cat=(%0d,%0d) mouse=(%0d,%0d) caught=%0b, want cat=(%0d,%0d) mouse=(%0d,%0d) caught=%0b",
               name, cat_x, cat_y, mouse_x, mouse_y, caught, px[0], py[0], px[1], py[1], m_caught);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    cat_req = 1'b0;
    mouse_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // One step: drives the requests, answers the wall lookup, checks grant choice,
  // lookup address, latency, ack, move_ok and the resulting grid state.
  task automatic do_op(input bit creq, input logic [1:0] cdir, input bit mreq,
                       input logic [1:0] mdir, input bit hit, input bit scramble);
    bit who, oob, exp_ok, got_ack, prev_rd;
    int tx, ty, exp_lat, rd_cnt;
    logic [1:0] d;
    who = (creq && mreq) ? !m_last_mouse : mreq;
    d = who ? mdir : cdir;
    tx = px[who]; ty = py[who];
    case (d)
      2'd0: tx = tx + 1;
      2'd1: ty = ty + 1;
      2'd2: tx = tx - 1;
      default: ty = ty - 1;
    endcase
    oob = (tx < 0) || (tx >= GRID_W) || (ty < 0) || (ty >= GRID_H);
`ifdef CATMOUSE_WRAP_EN
    tx = (tx + GRID_W) % GRID_W;
    ty = (ty + GRID_H) % GRID_H;
    oob = 1'b0;
`endif
    exp_lat = oob ? 2 : 4;
    exp_ok = !oob && !hit;
    cat_req = creq; cat_dir = cdir;
    mouse_req = mreq; mouse_dir = mdir;
    got_ack = 1'b0; prev_rd = 1'b0; rd_cnt = 0;
    for (int c = 2; c <= 10 && !got_ack; c++) begin
      @(posedge clk); #1;
      if (wall_rd) begin
        rd_cnt++;
        wall_hit = hit;
        tests_run++;
        if (c != 2 || wall_x !== 6'(tx) || wall_y !== 6'(ty)) begin
          tests_failed++;
          $display("FAIL wall_rd: cycle %0d addr (%0d,%0d), want cycle 2 addr (%0d,%0d)",
                   c, wall_x, wall_y, tx, ty);
        end
      end else if (!prev_rd) begin
        wall_hit = 1'($urandom_range(0, 1));
      end
      prev_rd = wall_rd;
      if (scramble && c == 2) begin
        cat_dir = 2'($urandom_range(0, 3));
        mouse_dir = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) begin
          cat_req = 1'b0;
          mouse_req = 1'b0;
        end
      end
      tests_run++;
      if (cat_ack || mouse_ack) begin
        got_ack = 1'b1;
        if (c != exp_lat || mouse_ack !== who || cat_ack !== !who || move_ok !== exp_ok) begin
          tests_failed++;
          $display("FAIL ack: cycle %0d cat_ack=%0b mouse_ack=%0b move_ok=%0b, want cycle %0d %s move_ok=%0b",
                   c, cat_ack, mouse_ack, move_ok, exp_lat, who ? "mouse" : "cat", exp_ok);
        end
      end else if (move_ok !== 1'b0) begin
        tests_failed++;
        $display("FAIL move_ok_idle: move_ok=%0b without ack at cycle %0d, want 0", move_ok, c);
      end
    end
    tests_run++;
    if (!got_ack || rd_cnt != (oob ? 0 : 1)) begin
      tests_failed++;
      $display("FAIL op_done: ack=%0b lookups=%0d, want ack=1 lookups=%0d", got_ack, rd_cnt, oob ? 0 : 1);
    end
    cat_req = 1'b0;
    mouse_req = 1'b0;
    m_last_mouse = who;
    if (exp_ok) begin
      px[who] = tx; py[who] = ty;
      if (px[0] == px[1] && py[0] == py[1]) m_caught = 1'b1;
    end
    @(posedge clk); #1;
    check_positions("post_commit");
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    model_reset();
    check_positions("reset_pos");
    tests_run++;
    if (wall_rd !== 1'b0 || cat_ack !== 1'b0 || mouse_ack !== 1'b0 || move_ok !== 1'b0 ||
        wall_x !== 6'd0 || wall_y !== 6'd0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_out: rd=%0b acks=%0b%0b ok=%0b wall=(%0d,%0d) st=%0d, want all 0",
               wall_rd, cat_ack, mouse_ack, move_ok, wall_x, wall_y, dbg_state);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    apply_reset();
    do_op(1, 2'd0, 0, 2'd0, 0, 0);
    do_op(1, 2'd1, 0, 2'd0, 1, 0);
    do_op(0, 2'd0, 1, 2'd2, 0, 0);
  endtask

  task automatic test_edges();
    apply_reset();
    do_op(0, 2'd0, 1, 2'd0, 0, 0);
    do_op(0, 2'd0, 1, 2'd1, 0, 0);
    do_op(1, 2'd2, 0, 2'd0, 0, 0);
    do_op(1, 2'd3, 0, 2'd0, 0, 0);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 8; i++)
      do_op(1, 2'($urandom_range(0, 3)), 1, 2'($urandom_range(0, 3)), 0, 0);
  endtask

  task automatic test_random();
    bit c, m;
    apply_reset();
    for (int i = 0; i < 80 && !m_caught; i++) begin
      c = 1'($urandom_range(0, 1));
      m = c ? 1'($urandom_range(0, 1)) : 1'b1;
      do_op(c, 2'($urandom_range(0, 3)), m, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), 1);
    end
  endtask

  task automatic move_to(input bit who, input int tx, input int ty);
    for (int i = 0; i < 64 && px[who] != tx; i++)
      if (who) do_op(0, 2'd0, 1, (tx > px[1]) ? 2'd0 : 2'd2, 0, 0);
      else     do_op(1, (tx > px[0]) ? 2'd0 : 2'd2, 0, 2'd0, 0, 0);
    for (int i = 0; i < 64 && py[who] != ty; i++)
      if (who) do_op(0, 2'd0, 1, (ty > py[1]) ? 2'd1 : 2'd3, 0, 0);
      else     do_op(1, (ty > py[0]) ? 2'd1 : 2'd3, 0, 2'd0, 0, 0);
  endtask

  task automatic test_caught();
    int acks;
    apply_reset();
    move_to(1, 5, 5);
    move_to(0, 4, 5);
    do_op(1, 2'd0, 0, 2'd0, 0, 0);
    acks = 0;
    cat_req = 1'b1; mouse_req = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (cat_ack || mouse_ack || wall_rd) acks++;
    end
    cat_req = 1'b0; mouse_req = 1'b0;
    tests_run++;
    if (acks != 0 || caught !== 1'b1) begin
      tests_failed++;
      $display("FAIL caught_freeze: activity=%0d caught=%0b, want activity=0 caught=1", acks, caught);
    end
  endtask

  task automatic test_reset_midop();
    int acks;
    apply_reset();
    do_op(1, 2'd0, 0, 2'd0, 0, 0);
    do_op(1, 2'd1, 0, 2'd0, 0, 0);
    cat_req = 1'b1; cat_dir = 2'd0;
    acks = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (cat_ack || mouse_ack) acks++;
    end
    rst = 1'b1;
    #1;
    model_reset();
    check_positions("reset_midop_pos");
    repeat (2) begin
      @(posedge clk); #1;
      if (cat_ack || mouse_ack || move_ok || wall_rd) acks++;
    end
    rst = 1'b0;
    cat_req = 1'b0;
    tests_run++;
    if (acks != 0) begin
      tests_failed++;
      $display("FAIL reset_midop_ack: %0d outputs active, want 0", acks);
    end
    @(posedge clk); #1;
    do_op(1, 2'd0, 0, 2'd0, 0, 0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_edges();
    test_back_to_back();
    test_random();
    test_reset_midop();
    test_caught();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
